seq_detector_prog: RTL and testbench

SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

---
 rtl/seq_detector_prog.sv | 90 +++++++++
 tb/tb_seq_detector_prog.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: shifts in valid bits, compares the newest
// len bits against a stored pattern, and counts matches in overlapping or non-overlapping mode.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter int                 DEF_LEN     = 4,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b1011,
    parameter logic               DEF_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   active_len
);

    localparam logic [LEN_W-1:0]   FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   RST_LEN  = (DEF_LEN > MAX_LEN) ? FILL_MAX : LEN_W'(DEF_LEN);
    localparam logic [MAX_LEN-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               hit;

    // NOTE: every signal written here gets a value on every path (defaults first), so no latch is inferred.
    always_comb begin
        hist_next       = {hist[MAX_LEN-2:0], in_bit};
        fill_next       = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);
        // Shifting by len == MAX_LEN empties the vector, giving an all-ones mask.
        mask            = ~(ALL_ONES << len);
        cfg_len_clamped = (cfg_len > FILL_MAX) ? FILL_MAX : cfg_len;
        hit             = 1'b0;
        if (in_valid && !cfg_we && (len != '0) && (fill_next >= len)
            && (((hist_next ^ pat) & mask) == '0)) begin
            hit = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat         <= DEF_PATTERN;
            len         <= RST_LEN;
            ovl         <= DEF_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= hit;

            // A configuration write takes precedence over a bit arriving in the same cycle.
            if (cfg_we) begin
                pat  <= cfg_pattern;
                len  <= cfg_len_clamped;
                ovl  <= cfg_overlap;
                fill <= '0;
            end else if (in_valid) begin
                hist <= hist_next;
                fill <= (hit && !ovl) ? '0 : fill_next;
            end

            if (count_clr) begin
                match_count <= '0;
            end else if (hit && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    assign active_len = len;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed scenarios followed by random
// traffic, all compared against a queue-based reference model of the detection rules.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               count_clr;

    logic               match_a, match_b;
    logic [7:0]         count_a;
    logic [1:0]         count_b;
    logic [LEN_W-1:0]   len_a, len_b;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit       m_hist[$];
    int       m_fill, m_len, m_pat, m_ovl;
    bit       m_match;
    int       m_cnt_a, m_cnt_b;

    always #5 clk = ~clk;

    seq_detector_prog dut_a (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .count_clr(count_clr),
        .match(match_a), .match_count(count_a), .active_len(len_a)
    );

    seq_detector_prog #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .count_clr(count_clr),
        .match(match_b), .match_count(count_b), .active_len(len_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // True when the newest len accepted bits, newest first, equal pattern bits 0..len-1.
    function automatic bit tail_matches();
        for (int k = 0; k < m_len; k++) begin
            if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < MAX_LEN; i++) m_hist.push_back(1'b0);
        m_fill  = 0;
        m_len   = 4;
        m_pat   = 'b1011;
        m_ovl   = 1;
        m_match = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
        if (cfg_we) begin
            m_pat  = int'(cfg_pattern);
            m_len  = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl  = int'(cfg_overlap);
            m_fill = 0;
        end else if (in_valid) begin
            m_hist.push_back(in_bit);
            void'(m_hist.pop_front());
            if (m_fill < MAX_LEN) m_fill++;
            if (m_len != 0 && m_fill >= m_len && tail_matches()) hit = 1'b1;
            if (hit && m_ovl == 0) m_fill = 0;
        end
        m_match = hit;
        if (count_clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (hit) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                        input logic o, input logic v, input logic b, input logic clr);
        @(negedge clk);
        reset       = rst;
        cfg_we      = we;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        in_valid    = v;
        in_bit      = b;
        count_clr   = clr;
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_match_a"}, match_a, m_match);
        check({tag, "_match_b"}, match_b, m_match);
        check({tag, "_count_a"}, count_a, m_cnt_a);
        check({tag, "_count_b"}, count_b, m_cnt_b);
        check({tag, "_len_a"},   len_a,   m_len);
    endtask

    task automatic bit_in(input string tag, input logic b, input logic clr = 1'b0);
        step(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, b, clr);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input string tag, input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                       input logic o, input logic v = 1'b0, input logic b = 1'b0);
        step(tag, 1'b0, 1'b1, p, l, o, v, b, 1'b0);
    endtask

    initial begin
        logic [6:0] seq7;
        model_reset();
        seq7 = 7'b1011011;

        // Defaults, overlapping: matches after bits 4 and 7
        do_reset("rst0");
        check("rst0_len_default", len_a, 4);
        check("rst0_count_zero", count_a, 0);
        for (int i = 6; i >= 0; i--) begin
            bit_in("ovl_seq", seq7[i]);
            check("ovl_seq_pulse", match_a, (i == 3 || i == 0) ? 1 : 0);
        end
        idle("ovl_idle");
        check("ovl_pulse_one_cycle", match_a, 0);
        check("ovl_count", count_a, 2);

        // Non-overlapping: only the 4th bit matches
        cfg("novl_cfg", 8'b1011, 4'd4, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            bit_in("novl_seq", seq7[i]);
            check("novl_seq_pulse", match_a, (i == 3) ? 1 : 0);
        end
        check("novl_count", count_a, 3);
        check("novl_count_sat2", count_b, 3);

        // Idle gaps do not break a partial sequence
        do_reset("rst1");
        for (int i = 3; i >= 0; i--) begin
            bit_in("gap_bit", seq7[i + 3]);
            check("gap_pulse", match_a, (i == 0) ? 1 : 0);
            if (i != 0) for (int g = 0; g < 3; g++) idle("gap_idle");
        end
        idle("gap_after");
        check("gap_count", count_a, 1);

        // cfg_we wins over a coincident bit and clears fill
        bit_in("cfgw_pre", 1'b1);
        bit_in("cfgw_pre", 1'b0);
        bit_in("cfgw_pre", 1'b1);
        cfg("cfgw_load", 8'b1011, 4'd4, 1'b1, 1'b1, 1'b1);
        check("cfgw_no_match", match_a, 0);
        for (int i = 3; i >= 0; i--) begin
            bit_in("cfgw_seq", seq7[i + 3]);
            check("cfgw_seq_pulse", match_a, (i == 0) ? 1 : 0);
        end
        check("cfgw_count_kept", count_a, 2);

        // Length clamping and zero-length disable
        cfg("clamp_cfg", 8'hA5, 4'd15, 1'b1);
        check("clamp_len_a", len_a, 8);
        check("clamp_len_b", len_b, 8);
        for (int i = 7; i >= 0; i--) bit_in("clamp_seq", 8'hA5 >> i);
        check("clamp_full_match", match_a, 1);
        cfg("zero_cfg", 8'h01, 4'd0, 1'b1);
        check("zero_len", len_a, 0);
        for (int i = 0; i < 10; i++) begin
            bit_in("zero_seq", 1'b1);
            check("zero_no_match", match_a, 0);
        end

        // Counter saturation on the 2-bit instance, then clear beats a match
        do_reset("rst2");
        for (int i = 3; i >= 0; i--) bit_in("sat_first", seq7[i + 3]);
        for (int r = 0; r < 4; r++) for (int i = 2; i >= 0; i--) bit_in("sat_rep", seq7[i]);
        check("sat_count_b", count_b, 3);
        check("sat_count_a", count_a, 5);
        bit_in("clr_pre", 1'b0);
        bit_in("clr_pre", 1'b1);
        bit_in("clr_hit", 1'b1, 1'b1);
        check("clr_match_pulse", match_b, 1);
        check("clr_count_b", count_b, 0);
        check("clr_count_a", count_a, 0);

        // Reset mid-sequence discards the partial match and restores defaults
        cfg("mid_cfg", 8'b11, 4'd2, 1'b0);
        bit_in("mid_pre", 1'b1);
        bit_in("mid_pre", 1'b0);
        bit_in("mid_pre", 1'b1);
        do_reset("mid_rst");
        bit_in("mid_post", 1'b1);
        check("mid_no_match", match_a, 0);
        check("mid_count", count_a, 0);
        check("mid_len_default", len_a, 4);

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 1) begin
                do_reset("rnd_rst");
            end else if (r < 8) begin
                step("rnd_cfg", 1'b0, 1'b1, 8'($urandom), 4'($urandom_range(0, 15)),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));
            end else begin
                step("rnd", 1'b0, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom),
                     1'($urandom_range(0, 9) < 7), 1'($urandom),
                     1'($urandom_range(0, 49) == 0));
            end
            if (n % 600 == 599) cfg("rnd_short", 8'($urandom), 4'($urandom_range(1, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
